// File: rtl/cmd_dispatch_pkg.sv
// Shared command-dispatch definitions: default timing parameters and FSM state encoding.
package cmd_dispatch_pkg;

  localparam int unsigned DEFAULT_RSP_LAT    = 1;
  localparam int unsigned DEFAULT_RX_TIMEOUT = 50000;

  typedef enum logic [1:0] {
    ST_RX    = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_TX    = 2'd3
  } state_e;

endpackage

// File: rtl/cmd_dispatch.sv
// Byte-serial command dispatcher: assembles a 32-bit command, strobes run, waits a fixed
// latency for the response word and streams it back out as four bytes, MSB first.
module cmd_dispatch
  import cmd_dispatch_pkg::*;
#(
  parameter int unsigned RSP_LAT    = DEFAULT_RSP_LAT,
  parameter int unsigned RX_TIMEOUT = DEFAULT_RX_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        run,
  output logic [31:0] cmd,
  input  logic [31:0] rsp,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        frame_err
);

  localparam int unsigned IDLE_W = $clog2(RX_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [31:0]       cmd_q, cmd_d;
  logic [31:0]       rsp_q, rsp_d;
  logic [3:0]        lat_cnt_q, lat_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d, idle_inc;
  logic              frame_err_q, frame_err_d;
  logic              rx_fire, tx_fire;

  assign rx_ready  = (state_q == ST_RX);
  assign tx_valid  = (state_q == ST_TX);
  assign run       = (state_q == ST_ISSUE);
  assign rx_fire   = rx_valid & rx_ready;
  assign tx_fire   = tx_valid & tx_ready;
  assign cmd       = cmd_q;
  assign frame_err = frame_err_q;
  assign idle_inc  = idle_cnt_q + IDLE_W'(1);

  // The byte counter is reused in TX to pick the outgoing byte of the captured word.
  always_comb begin
    tx_data = 8'h00;
    case (byte_cnt_q)
      2'd0: tx_data = rsp_q[31:24];
      2'd1: tx_data = rsp_q[23:16];
      2'd2: tx_data = rsp_q[15:8];
      2'd3: tx_data = rsp_q[7:0];
      default: tx_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    cmd_d       = cmd_q;
    rsp_d       = rsp_q;
    lat_cnt_d   = lat_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    frame_err_d = 1'b0;

    case (state_q)
      ST_RX: begin
        if (rx_fire) begin
          idle_cnt_d = '0;
          if (byte_cnt_q == 2'd3) begin
            // Publish the word only once complete so exe blocks never see a partial command.
            cmd_d      = {shift_q, rx_data};
            byte_cnt_d = 2'd0;
            state_d    = ST_ISSUE;
          end else begin
            shift_d    = {shift_q[15:0], rx_data};
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (byte_cnt_q != 2'd0) begin
          if (idle_inc == IDLE_W'(RX_TIMEOUT)) begin
            byte_cnt_d  = 2'd0;
            idle_cnt_d  = '0;
            frame_err_d = 1'b1;
          end else begin
            idle_cnt_d = idle_inc;
          end
        end
      end

      ST_ISSUE: begin
        lat_cnt_d = 4'd0;
        state_d   = ST_WAIT;
      end

      ST_WAIT: begin
        // lat_cnt_q holds k-1 during cycle T+k, so capture lands on cycle T+RSP_LAT.
        if (lat_cnt_q == 4'(RSP_LAT - 1)) begin
          rsp_d   = rsp;
          state_d = ST_TX;
        end else begin
          lat_cnt_d = lat_cnt_q + 4'd1;
        end
      end

      ST_TX: begin
        if (tx_fire) begin
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = 2'd0;
            state_d    = ST_RX;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

      default: state_d = ST_RX;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RX;
      byte_cnt_q  <= 2'd0;
      shift_q     <= 24'd0;
      cmd_q       <= 32'd0;
      rsp_q       <= 32'd0;
      lat_cnt_q   <= 4'd0;
      idle_cnt_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      cmd_q       <= cmd_d;
      rsp_q       <= rsp_d;
      lat_cnt_q   <= lat_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: doc/cmd_dispatch.md
CMD_DISPATCH -- requirements
Module: cmd_dispatch

Interface
REQ-001 Parameter RSP_LAT, default 1: clock cycles from the run cycle to the rsp sample cycle; legal range 1..15.
REQ-002 Parameter RX_TIMEOUT, default 50000: idle cycles allowed between bytes of one command before that partial command is discarded.
REQ-003 Port clk, input, 1: single block clock; every register is clocked on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port rx_data, input, 8: inbound command byte.
REQ-006 Port rx_valid, input, 1: rx_data is valid.
REQ-007 Port rx_ready, output, 1: block accepts a byte; a transfer occurs on a cycle where rx_valid and rx_ready are both high.
REQ-008 Port run, output, 1: one-cycle strobe that issues cmd to the exe blocks.
REQ-009 Port cmd, output, 32: assembled command word; stable from the run cycle until the next command issues.
REQ-010 Port rsp, input, 32: response word from the addressed exe block.
REQ-011 Port tx_data, output, 8: outbound response byte.
REQ-012 Port tx_valid, output, 1: tx_data is valid.
REQ-013 Port tx_ready, input, 1: downstream accepts the byte; a transfer occurs when tx_valid and tx_ready are both high.
REQ-014 Port frame_err, output, 1: one-cycle pulse when a partial command is discarded on timeout.

Function
REQ-015 The FSM SHALL have exactly the states RX, ISSUE, WAIT and TX.
REQ-016 In RX, rx_ready SHALL be 1; it SHALL be 0 in every other state.
REQ-017 In RX, bytes SHALL shift into the command register MSB first: byte 0 -> cmd[31:24], byte 3 -> cmd[7:0].
REQ-018 A 2-bit byte counter SHALL advance on each accepted byte; accepting byte 3 SHALL move the FSM to ISSUE and clear the counter.
REQ-019 In ISSUE, run SHALL be 1 for exactly one cycle, and the FSM SHALL then move to WAIT.
REQ-020 cmd SHALL update only when byte 3 is accepted, never on bytes 0-2; exe blocks therefore never see a half-built word while run is 1.
REQ-021 WAIT SHALL count cycles so that rsp is captured on the clock edge ending cycle T+RSP_LAT, where T is the run cycle; the FSM SHALL then move to TX.
REQ-022 In TX, the captured rsp SHALL be sent as 4 bytes MSB first; tx_valid SHALL stay 1 and tx_data SHALL stay stable until each byte is accepted.
REQ-023 If tx_ready is held low, TX SHALL stall indefinitely with no data loss.
REQ-024 When the 4th tx byte is accepted, the FSM SHALL return to RX; the first byte of the next command can be accepted on the following cycle.
REQ-025 An inactivity counter SHALL run only in RX while the byte counter is nonzero, and SHALL clear on every accepted byte.
REQ-026 When the inactivity counter reaches RX_TIMEOUT, the byte counter SHALL clear, frame_err SHALL pulse, cmd SHALL hold its previous value, and no run SHALL occur.
REQ-027 If a byte is accepted on the same cycle the timeout would fire, the byte SHALL be taken and the timeout SHALL not fire.
REQ-028 The block SHALL be protocol-agnostic: no decoding of target or instruction fields, and every rsp value, including error-marked ones, SHALL be forwarded verbatim.
REQ-029 Exactly one command SHALL be in flight at a time; there is no pipelining across commands.

Reset
REQ-030 While rst_n is low, the block SHALL hold: state RX, counters 0, cmd 0, captured rsp 0, run 0, tx_valid 0, tx_data 0, frame_err 0.
REQ-031 Because rx_ready is high in RX, it SHALL read 1 during reset.
REQ-032 Reset asserted mid-command, mid-WAIT or mid-TX SHALL abandon the transaction with no further run and no further tx bytes.

Structure
REQ-033 The shared command definitions include file SHALL hold the default RSP_LAT and RX_TIMEOUT values and the state encodings.
REQ-034 The design SHALL be a single module with no sub-modules; the byte serializer SHALL be inline shift logic.

Verification
REQ-035 Bytes 0x12,0x34,0x56,0x78 with a model exe block returning cmd -> one run pulse with cmd=0x12345678; tx bytes 12,34,56,78.
REQ-036 Model returns cmd with an error bit set (e.g. 0x92345678) -> tx bytes 92,34,56,78, forwarded unchanged.
REQ-037 RX_TIMEOUT=100; send 2 bytes, then idle 100 cycles -> frame_err pulse, no run; next 4 bytes decode correctly.
REQ-038 Hold tx_ready low 20 cycles during TX -> tx_data stable, rx_ready 0 throughout, all 4 bytes delivered in order.
REQ-039 Assert rst_n low during WAIT -> no run, no tx_valid; after release, a normal command completes.
REQ-040 RSP_LAT=3 with a model rsp that is valid only in cycle T+3 -> correct word captured and transmitted.
